hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller sitting beside the forwarding unit in the ID/EX boundary of the 5-stage RV32 core. It covers what forwarding cannot: it stalls on load-use dependencies, holds the front of the pipe while a multi-cycle multiply/divide unit (MDU) is busy, and flushes wrong-path instructions on a taken branch or jump resolved in EX. It optionally counts stall and flush cycles for the benchmarking framework.

## Interface
- MDU_TIMEOUT, default 64: maximum number of MDU_BUSY cycles before `mdu_timeout_err` is raised.
- CNT_W, default 32: width of each performance counter.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rs1_id, rs2_id  in  5 each  source register addresses of the instruction in ID
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads that operand
- rd_ex  in  5  destination register of the instruction in EX
- mem_read_ex  in  1  the EX instruction is a load
- branch_taken_ex  in  1  the EX branch/jump redirects the PC this cycle
- mdu_start  in  1  an MDU op occupies EX this cycle and has not yet been accepted
- mdu_done  in  1  the MDU result is valid this cycle
- pc_stall  out  1  hold the PC
- if_id_stall  out  1  hold the IF/ID register
- id_ex_stall  out  1  hold the ID/EX register
- if_id_flush  out  1  clear the IF/ID register to a NOP
- id_ex_flush  out  1  clear the ID/EX register to a NOP
- ex_mem_bubble  out  1  insert a NOP into EX/MEM
- mdu_timeout_err  out  1  sticky error flag
- load_use_cnt, mdu_stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- FSM states:
  - RUN: normal operation.
  - MDU_BUSY: waiting for the MDU result.
- Transitions:
  - RUN→MDU_BUSY when `mdu_start` is high and `mdu_done` is low.
  - MDU_BUSY→RUN when `mdu_done` is high.
  - `mdu_start` with `mdu_done` in the same cycle (single-cycle op) stays in RUN with no stall.
- load_use = `mem_read_ex` & (`rd_ex` != 0) & ((`rs1_used_id` & `rs1_id` == `rd_ex`) | (`rs2_used_id` & `rs2_id` == `rd_ex`)).
- mdu_hold = (RUN & `mdu_start` & !`mdu_done`) | (MDU_BUSY & !`mdu_done`).
- Output priority: branch > mdu_hold > load_use.
  - Branch: `if_id_flush`=1 and `id_ex_flush`=1. No stalls, since the PC loads the target.
  - mdu_hold: `pc_stall`, `if_id_stall` and `id_ex_stall` = 1, and `ex_mem_bubble`=1.
  - load_use: `pc_stall`=1, `if_id_stall`=1 and `id_ex_flush`=1. This gives one bubble, after which the forwarding unit supplies the value from MEM/WB.
- Branch together with mdu_hold cannot be legal, because EX holds only one instruction. If it occurs anyway, the branch wins and the FSM still follows `mdu_done`.
- Timeout: the busy counter clears on entry to MDU_BUSY and increments each MDU_BUSY cycle. When it reaches MDU_TIMEOUT, `mdu_timeout_err` sets and stays set until `rst`. The FSM keeps waiting.

## Timing
- All stall, flush and bubble outputs are combinational from the current state and inputs, with zero latency.
- State, busy counter, error flag and performance counters are registered on `clk`.
- While `rst` is high:
  - every output is forced to 0;
  - the next state is RUN;
  - the busy counter, error flag and all counters become 0.
- Reset during MDU_BUSY abandons the operation. The MDU is reset by the same `rst`.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM and load_use evaluates false.
- An MDU op with latency N (start at cycle 0, done at cycle N) gives stall outputs high in cycles 0..N-1 and low in cycle N.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `load_use_cnt` increments on every cycle where load_use is the active cause.
  - `mdu_stall_cnt` increments on every mdu_hold cycle.
  - `flush_cnt` increments on every branch flush cycle.
  - All three saturate at 2^CNT_W−1 and do not wrap.
- `HAZARD_PERF_CNT_EN` undefined: no counter flops are built and the three outputs are tied to 0.

## Structure
- The shared package (alongside the forwarding defines) holds:
  - the FSM enum `hazard_state_t` {RUN, MDU_BUSY};
  - the NOP encoding 32'h0000_0013 used by stages when applying flush/bubble.
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `rst`, `inc`; output `count`), is instantiated three times under the macro.

## Test plan
- Load to x5 in EX, ID reads x5 on rs2 with `rs2_used_id`=1 → one cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1, then all 0. With the macro, `load_use_cnt`=1.
- Same case but `rd_ex`=0, or `rs2_used_id`=0 → no stall.
- `mdu_start` at cycle 0, `mdu_done` at cycle 4 → stalls and `ex_mem_bubble` high in cycles 0–3, low in cycle 4, state back to RUN. `mdu_stall_cnt`=4.
- `branch_taken_ex` together with a load-use condition → only `if_id_flush`=`id_ex_flush`=1, no stall. `flush_cnt`=1.
- MDU_TIMEOUT=8, `mdu_done` never asserted → `mdu_timeout_err` rises after 8 busy cycles and stays set. Asserting `rst` clears it and all outputs are 0.
- Counter saturation with CNT_W=4: 20 consecutive mdu_hold cycles → `mdu_stall_cnt` holds at 15.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared hazard/forwarding definitions: FSM state type, pipeline NOP encoding,
// the hazard control bundle and a source-operand match helper.
package hazard_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hazard_state_t;

  // addi x0, x0, 0 -- written by a stage when it is flushed or bubbled
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
  } hazard_ctl_t;

  function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, MDU hold and branch flush control for the ID/EX boundary.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mdu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BW = $clog2(MDU_TIMEOUT + 1);

  hazard_state_t r_state;
  logic [BW-1:0] r_busy_cnt;
  logic          r_err;

  logic          w_load_use;
  logic          w_mdu_hold;
  logic          w_branch;
  logic [BW-1:0] w_busy_nxt;
  hazard_ctl_t   w_ctl;

  always_comb begin
    w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                 (src_hit(rs1_used_id, rs1_id, rd_ex) ||
                  src_hit(rs2_used_id, rs2_id, rd_ex));
    w_mdu_hold = (r_state == RUN)      ? (mdu_start && !mdu_done)
                                       : !mdu_done;
    w_branch   = branch_taken_ex;
  end

  // Busy counter stops at the timeout value so it can never wrap back below it.
  assign w_busy_nxt = (r_busy_cnt == BW'(MDU_TIMEOUT)) ? r_busy_cnt
                                                       : r_busy_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (mdu_start && !mdu_done) begin
            r_state    <= MDU_BUSY;
            r_busy_cnt <= '0;
          end
        end
        MDU_BUSY: begin
          r_busy_cnt <= w_busy_nxt;
          if (w_busy_nxt == BW'(MDU_TIMEOUT)) begin
            r_err <= 1'b1;
          end
          if (mdu_done) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Priority branch > mdu_hold > load_use; everything is held low during reset.
  always_comb begin
    w_ctl = '0;
    if (!rst) begin
      if (w_branch) begin
        w_ctl.if_id_flush = 1'b1;
        w_ctl.id_ex_flush = 1'b1;
      end else if (w_mdu_hold) begin
        w_ctl.pc_stall      = 1'b1;
        w_ctl.if_id_stall   = 1'b1;
        w_ctl.id_ex_stall   = 1'b1;
        w_ctl.ex_mem_bubble = 1'b1;
      end else if (w_load_use) begin
        w_ctl.pc_stall    = 1'b1;
        w_ctl.if_id_stall = 1'b1;
        w_ctl.id_ex_flush = 1'b1;
      end
    end
  end

  assign pc_stall        = w_ctl.pc_stall;
  assign if_id_stall     = w_ctl.if_id_stall;
  assign id_ex_stall     = w_ctl.id_ex_stall;
  assign if_id_flush     = w_ctl.if_id_flush;
  assign id_ex_flush     = w_ctl.id_ex_flush;
  assign ex_mem_bubble   = w_ctl.ex_mem_bubble;
  assign mdu_timeout_err = r_err && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic             w_inc_lu;
  logic [CNT_W-1:0] w_lu_cnt;
  logic [CNT_W-1:0] w_ms_cnt;
  logic [CNT_W-1:0] w_fl_cnt;

  assign w_inc_lu = w_load_use && !w_branch && !w_mdu_hold;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_lu),
    .count (w_lu_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ms_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_mdu_hold),
    .count (w_ms_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fl_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_branch),
    .count (w_fl_cnt)
  );

  assign load_use_cnt  = rst ? '0 : w_lu_cnt;
  assign mdu_stall_cnt = rst ? '0 : w_ms_cnt;
  assign flush_cnt     = rst ? '0 : w_fl_cnt;
`else
  assign load_use_cnt  = '0;
  assign mdu_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MDU_TIMEOUT=8, CNT_W=4); honours HAZARD_PERF_CNT_EN.
module tb_hazard_unit;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_HOLD = 6'b111001;
  localparam logic [5:0] C_LU   = 6'b110010;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex;
  logic          mdu_start, mdu_done;
  logic          pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble;
  logic          mdu_timeout_err;
  logic [CW-1:0] load_use_cnt, mdu_stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_busy;
  int m_cyc;
  bit m_err;
  int m_lu, m_ms, m_fl;

  always #5 clk = ~clk;

  hazard_unit #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .branch_taken_ex (branch_taken_ex),
    .mdu_start       (mdu_start),
    .mdu_done        (mdu_done),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_bubble   (ex_mem_bubble),
    .mdu_timeout_err (mdu_timeout_err),
    .load_use_cnt    (load_use_cnt),
    .mdu_stall_cnt   (mdu_stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  wire [5:0]      obs_ctl  = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble};
  wire [3*CW:0]   obs_regs = {mdu_timeout_err, load_use_cnt, mdu_stall_cnt, flush_cnt};

  function automatic bit model_lu();
    return mem_read_ex && (rd_ex != 0) &&
           ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));
  endfunction

  function automatic bit model_hold();
    return m_busy ? !mdu_done : (mdu_start && !mdu_done);
  endfunction

  function automatic logic [5:0] exp_ctl();
    if (rst) return C_NONE;
    if (branch_taken_ex) return C_BR;
    if (model_hold()) return C_HOLD;
    if (model_lu()) return C_LU;
    return C_NONE;
  endfunction

  function automatic logic [3*CW:0] exp_regs();
    logic [3*CW:0] v;
    v = '0;
    if (!rst) begin
      v[3*CW] = m_err;
      if (PERF) v[3*CW-1:0] = {CW'(m_lu), CW'(m_ms), CW'(m_fl)};
    end
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x + 1 > CMAX) ? CMAX : x + 1;
  endfunction

  // Update the model with the inputs present at this edge, then move to the next cycle.
  task automatic advance();
    bit lu, hold, br;
    lu   = model_lu();
    hold = model_hold();
    br   = branch_taken_ex;
    if (rst) begin
      m_busy = 0; m_cyc = 0; m_err = 0; m_lu = 0; m_ms = 0; m_fl = 0;
    end else begin
      if (hold) m_ms = sat(m_ms);
      if (br) m_fl = sat(m_fl);
      if (lu && !br && !hold) m_lu = sat(m_lu);
      if (m_busy) begin
        m_cyc++;
        if (m_cyc >= TO) m_err = 1;
        if (mdu_done) m_busy = 0;
      end else if (mdu_start && !mdu_done) begin
        m_busy = 1;
        m_cyc  = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_id = 0; rs2_id = 0; rd_ex = 0;
    rs1_used_id = 0; rs2_used_id = 0; mem_read_ex = 0;
    branch_taken_ex = 0; mdu_start = 0; mdu_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    advance();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    rs1_id = 5; rs2_id = 5; rd_ex = 5; rs1_used_id = 1; rs2_used_id = 1;
    mem_read_ex = 1; branch_taken_ex = 1; mdu_start = 1; mdu_done = 0;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl got %b exp %b", obs_ctl, C_NONE); end
    n_cmp++;
    if (obs_regs !== '0) begin n_err++; $display("FAIL reset_regs got %h exp 0", obs_regs); end
    advance();
    idle_inputs();
    rst = 0;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE || obs_regs !== exp_regs()) begin
      n_err++; $display("FAIL post_reset got ctl %b regs %h exp ctl %b regs %h", obs_ctl, obs_regs, C_NONE, exp_regs());
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    // load to x5 in EX, ID reads x5 on rs2
    rd_ex = 5; mem_read_ex = 1; rs2_id = 5; rs2_used_id = 1; rs1_id = 3; rs1_used_id = 1;
    #1;
    n_cmp++;
    if (obs_ctl !== C_LU) begin n_err++; $display("FAIL lu_stall got %b exp %b", obs_ctl, C_LU); end
    advance();
    mem_read_ex = 0; rd_ex = 7;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE) begin n_err++; $display("FAIL lu_release got %b exp %b", obs_ctl, C_NONE); end
    n_cmp++;
    if (load_use_cnt !== (PERF ? CW'(1) : CW'(0))) begin
      n_err++; $display("FAIL lu_cnt got %0d exp %0d", load_use_cnt, PERF ? 1 : 0);
    end
    advance();
    // rd_ex = x0 never stalls
    rd_ex = 0; mem_read_ex = 1; rs2_id = 0; rs2_used_id = 1; rs1_id = 0;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE) begin n_err++; $display("FAIL lu_x0 got %b exp %b", obs_ctl, C_NONE); end
    advance();
    // operand not used
    rd_ex = 5; rs2_id = 5; rs2_used_id = 0; rs1_id = 2; rs1_used_id = 1;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE) begin n_err++; $display("FAIL lu_unused got %b exp %b", obs_ctl, C_NONE); end
    advance();
    // rs1 path
    rs1_id = 5;
    #1;
    n_cmp++;
    if (obs_ctl !== C_LU) begin n_err++; $display("FAIL lu_rs1 got %b exp %b", obs_ctl, C_LU); end
    advance();
    idle_inputs();
  endtask

  task automatic test_mdu_latency();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      mdu_start = (c == 0);
      mdu_done  = (c == 4);
      #1;
      n_cmp++;
      if (obs_ctl !== ((c < 4) ? C_HOLD : C_NONE)) begin
        n_err++; $display("FAIL mdu_lat c%0d got %b exp %b", c, obs_ctl, (c < 4) ? C_HOLD : C_NONE);
      end
      if (c == 5) begin
        n_cmp++;
        if (mdu_stall_cnt !== (PERF ? CW'(4) : CW'(0))) begin
          n_err++; $display("FAIL mdu_cnt got %0d exp %0d", mdu_stall_cnt, PERF ? 4 : 0);
        end
        // back in RUN: a load-use must be seen again
        rd_ex = 9; mem_read_ex = 1; rs1_id = 9; rs1_used_id = 1;
        #1;
        n_cmp++;
        if (obs_ctl !== C_LU) begin n_err++; $display("FAIL mdu_back_run got %b exp %b", obs_ctl, C_LU); end
      end
      advance();
    end
    // single-cycle op: start and done together, no stall
    idle_inputs();
    mdu_start = 1; mdu_done = 1;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE) begin n_err++; $display("FAIL mdu_single got %b exp %b", obs_ctl, C_NONE); end
    advance();
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    rd_ex = 5; mem_read_ex = 1; rs2_id = 5; rs2_used_id = 1; branch_taken_ex = 1;
    #1;
    n_cmp++;
    if (obs_ctl !== C_BR) begin n_err++; $display("FAIL br_prio got %b exp %b", obs_ctl, C_BR); end
    advance();
    idle_inputs();
    #1;
    n_cmp++;
    if (flush_cnt !== (PERF ? CW'(1) : CW'(0)) || load_use_cnt !== '0) begin
      n_err++; $display("FAIL br_cnt got fl %0d lu %0d exp fl %0d lu 0", flush_cnt, load_use_cnt, PERF ? 1 : 0);
    end
    advance();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      mdu_start = 1; mdu_done = 0;
      #1;
      n_cmp++;
      if (mdu_timeout_err !== (c >= TO + 1)) begin
        n_err++; $display("FAIL timeout c%0d got %b exp %b", c, mdu_timeout_err, c >= TO + 1);
      end
      advance();
    end
    rst = 1;
    #1;
    n_cmp++;
    if (obs_ctl !== C_NONE || obs_regs !== '0) begin
      n_err++; $display("FAIL timeout_rst got ctl %b regs %h exp 0", obs_ctl, obs_regs);
    end
    advance();
    rst = 0; idle_inputs();
    #1;
    n_cmp++;
    if (mdu_timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear got %b exp 0", mdu_timeout_err); end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    mdu_start = 1; mdu_done = 0;
    for (int c = 0; c < 20; c++) advance();
    mdu_done = 1;
    #1;
    n_cmp++;
    if (mdu_stall_cnt !== (PERF ? CW'(CMAX) : CW'(0))) begin
      n_err++; $display("FAIL sat got %0d exp %0d", mdu_stall_cnt, PERF ? CMAX : 0);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 49) == 0);
      rs1_id      = 5'($urandom_range(0, 3));
      rs2_id      = 5'($urandom_range(0, 3));
      rd_ex       = 5'($urandom_range(0, 3));
      rs1_used_id = 1'($urandom_range(0, 1));
      rs2_used_id = 1'($urandom_range(0, 1));
      mem_read_ex = 1'($urandom_range(0, 1));
      branch_taken_ex = 0; mdu_start = 0; mdu_done = 0;
      if (m_busy) begin
        mdu_start = 1'($urandom_range(0, 1));
        mdu_done  = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 7) == 0) begin
        mdu_start = 1;
        mdu_done  = ($urandom_range(0, 3) == 0);
      end else begin
        branch_taken_ex = ($urandom_range(0, 7) == 0);
      end
      #1;
      n_cmp++;
      if (obs_ctl !== exp_ctl() || obs_regs !== exp_regs()) begin
        n_err++;
        $display("FAIL rand c%0d got ctl %b regs %h exp ctl %b regs %h", c, obs_ctl, obs_regs, exp_ctl(), exp_regs());
      end
      advance();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_busy = 0; m_cyc = 0; m_err = 0; m_lu = 0; m_ms = 0; m_fl = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mdu_latency();
    test_branch_priority();
    test_timeout();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
